// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// imem_pkg : fault codes and defaults shared by the instruction-memory port
// Rev 1.0   (optional feature macro: IMEM_PARITY_EN)
// ============================================================================
package imem_pkg;

  typedef logic [1:0] fault_t;

  localparam fault_t FAULT_OK       = 2'd0;
  localparam fault_t FAULT_MISALIGN = 2'd1;
  localparam fault_t FAULT_RANGE    = 2'd2;
  localparam fault_t FAULT_PARITY   = 2'd3;

  localparam logic [31:0] DEFAULT_NOP = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/imem_fetch_port_if.sv
`default_nettype none
// ============================================================================
// imem_fetch_port_if : fetch handshake, response and load-port bundle
// Rev 1.0
// ============================================================================
interface imem_fetch_port_if
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_pc;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_instr;
  logic [ADDR_W-1:0] rsp_pc;
  fault_t            rsp_fault;
  logic              flush;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_err;

  modport master (
    output req_valid, req_pc, rsp_ready, flush, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault, ld_err
  );

  modport slave (
    input  req_valid, req_pc, rsp_ready, flush, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault, ld_err
  );
endinterface
`default_nettype wire

// File: rtl/imem_byte_array.sv
`default_nettype none
// ============================================================================
// imem_byte_array : byte storage, word-wide sync write and registered read
// Rev 1.0   (optional per-byte even parity under IMEM_PARITY_EN)
// ============================================================================
module imem_byte_array #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 1024,
  localparam int BYTES      = DATA_W / 8,
  localparam int IDX_W      = $clog2(DEPTH_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_par_err
);

  logic [7:0] mem [DEPTH_BYTES];

  // Storage carries no reset: contents only ever come from the load port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        mem[wr_addr + IDX_W'(b)] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      for (int b = 0; b < BYTES; b++) begin
        rd_data[8*b +: 8] <= mem[rd_addr + IDX_W'(b)];
      end
    end
  end

`ifdef IMEM_PARITY_EN
  logic             par_mem [DEPTH_BYTES];
  logic [BYTES-1:0] rd_par;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        par_mem[wr_addr + IDX_W'(b)] <= ^wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_par <= '0;
    end else if (rd_en) begin
      for (int b = 0; b < BYTES; b++) begin
        rd_par[b] <= par_mem[rd_addr + IDX_W'(b)];
      end
    end
  end

  always_comb begin
    rd_par_err = 1'b0;
    for (int b = 0; b < BYTES; b++) begin
      if ((^rd_data[8*b +: 8]) != rd_par[b]) begin
        rd_par_err = 1'b1;
      end
    end
  end
`else
  assign rd_par_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/imem_fetch_port.sv
`default_nettype none
// ============================================================================
// imem_fetch_port : registered instruction memory with valid/ready fetch port
// Rev 1.0   (optional parity checking: define IMEM_PARITY_EN)
// ============================================================================
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_BYTES = 1024,
  parameter int                ADDR_W      = 32,
  parameter logic [DATA_W-1:0] NOP_WORD    = DATA_W'(DEFAULT_NOP)
) (
  input  logic             clk,
  input  logic             rst,
  imem_fetch_port_if.slave bus
);

  localparam int                BYTES      = DATA_W / 8;
  localparam int                IDX_W      = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] MAX_PC     = ADDR_W'(DEPTH_BYTES - BYTES);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] pc_q;
  fault_t            fault_q;
  logic              ld_err_q;
  fault_t            req_fault;
  logic              accept;
  logic              take;
  logic              ld_ok;
  logic [DATA_W-1:0] rd_data;
  logic              rd_par_err;

  assign bus.rsp_valid = (state == ST_FULL);
  assign bus.req_ready = rst & ~bus.ld_en & (~bus.rsp_valid | bus.rsp_ready);
  assign accept        = bus.req_valid & bus.req_ready;
  assign take          = accept & ~bus.flush;

  // Compare at full address width so a PC near the top of the space never wraps.
  always_comb begin
    req_fault = FAULT_OK;
    if ((bus.req_pc & ALIGN_MASK) != '0) begin
      req_fault = FAULT_MISALIGN;
    end else if (bus.req_pc > MAX_PC) begin
      req_fault = FAULT_RANGE;
    end
  end

  assign ld_ok = ((bus.ld_addr & ALIGN_MASK) == '0) && (bus.ld_addr <= MAX_PC);

  imem_byte_array #(
    .DATA_W      (DATA_W),
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (bus.ld_en & ld_ok),
    .wr_addr    (bus.ld_addr[IDX_W-1:0]),
    .wr_data    (bus.ld_data),
    .rd_en      (take && (req_fault == FAULT_OK)),
    .rd_addr    (bus.req_pc[IDX_W-1:0]),
    .rd_data    (rd_data),
    .rd_par_err (rd_par_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_EMPTY;
      pc_q     <= '0;
      fault_q  <= FAULT_OK;
      ld_err_q <= 1'b0;
    end else begin
      ld_err_q <= bus.ld_en & ~ld_ok;
      if (take) begin
        pc_q    <= bus.req_pc;
        fault_q <= req_fault;
      end
      case (state)
        ST_EMPTY: if (take) state <= ST_FULL;
        ST_FULL: begin
          if (bus.flush) begin
            state <= ST_EMPTY;
          end else if (bus.rsp_ready && !accept) begin
            state <= ST_EMPTY;
          end
        end
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  // Parity only overrides an otherwise clean fetch; raw data stays visible.
  assign bus.rsp_fault = ((fault_q == FAULT_OK) && rd_par_err) ? FAULT_PARITY : fault_q;
  assign bus.rsp_instr = (fault_q == FAULT_OK) ? rd_data : NOP_WORD;
  assign bus.rsp_pc    = pc_q;
  assign bus.ld_err    = ld_err_q;

endmodule
`default_nettype wire
